// File: rtl/partida_pkg.sv
// ---------------------------------------------------------------------------
// partida_pkg
// Shared types and helpers for the star-delta starter sequencer.
//   estado_t   : sequencer states, encoded as exported on the estado port
//   saidas_t   : contactor/fault output bundle for one state
//   ms_div     : clock cycles per millisecond
//   max3       : largest of three durations, used to size the ms counter
//   decodifica : state -> output bundle
// ---------------------------------------------------------------------------
package partida_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      STAR  = 3'd1,
      DEAD  = 3'd2,
      DELTA = 3'd3,
      COOL  = 3'd4,
      FAULT = 3'd5
   } estado_t;

   typedef struct packed {
      logic k1;
      logic k2;
      logic k3;
      logic falha;
   } saidas_t;

   function automatic int ms_div(input int clk_hz);
      return clk_hz / 1000;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic saidas_t decodifica(input estado_t s);
      saidas_t o;
      o = '0;
      case (s)
         STAR:    begin o.k1 = 1'b1; o.k2 = 1'b1; end
         DEAD:    o.k1 = 1'b1;
         DELTA:   begin o.k1 = 1'b1; o.k3 = 1'b1; end
         FAULT:   o.falha = 1'b1;
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/temporizador_ms.sv
// ---------------------------------------------------------------------------
// temporizador_ms
// Millisecond phase timer: a prescaler dividing the clock by MS_DIV feeding a
// saturating millisecond counter.
//   clk, rst   : clock, asynchronous active-high reset
//   restart    : high during the first cycle of a new phase
//   target_ms  : phase length in ms (>= 1)
//   done       : high on the last cycle of the phase and held until restart
// A phase of N ms therefore lasts exactly N*MS_DIV cycles of its owner.
// ---------------------------------------------------------------------------
module temporizador_ms #(
   parameter int MS_DIV = 25000,
   parameter int MS_W   = 14,
   parameter int PRE_W  = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            restart,
   input  logic [MS_W-1:0] target_ms,
   output logic            done
);

   logic [PRE_W-1:0] pre;
   logic [PRE_W-1:0] pre_base;
   logic [MS_W-1:0]  ms;
   logic [MS_W-1:0]  ms_base;
   logic             tick;
   logic             at_target;

   // The restart cycle already belongs to the new phase, so it is counted
   // from a zero base instead of spending a cycle clearing the registers.
   assign pre_base  = restart ? '0 : pre;
   assign ms_base   = restart ? '0 : ms;
   assign tick      = (pre_base == PRE_W'(MS_DIV - 1));
   assign at_target = (ms_base == target_ms);
   assign done      = at_target | ((ms_base == target_ms - MS_W'(1)) & tick);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre <= '0;
         ms  <= '0;
      end else if (at_target) begin
         // Terminal value: hold, never wrap.
         pre <= pre_base;
         ms  <= ms_base;
      end else if (tick) begin
         pre <= '0;
         ms  <= ms_base + MS_W'(1);
      end else begin
         pre <= pre_base + PRE_W'(1);
         ms  <= ms_base;
      end
   end

endmodule

// File: rtl/partida_estrela_triangulo.sv
// ---------------------------------------------------------------------------
// partida_estrela_triangulo
// Star-delta motor starter sequencer driven by the sealed run level.
//   clk, rst   : clock, asynchronous active-high reset
//   run        : run request (sealed, debounced)
//   overload   : thermal relay trip, 1 = tripped (debounced)
//   k1_main    : main contactor
//   k2_star    : star contactor
//   k3_delta   : delta contactor
//   em_falha   : 1 while in FAULT
//   estado     : current state encoding
// Sequence IDLE -> STAR -> DEAD -> DELTA, COOL enforces the minimum off time,
// overload forces FAULT from anywhere. All outputs are registered and change
// on the same edge as the state register.
// ---------------------------------------------------------------------------
module partida_estrela_triangulo
   import partida_pkg::*;
#(
   parameter int CLK_HZ    = 25_000_000,
   parameter int T_STAR_MS = 5000,
   parameter int T_DEAD_MS = 50,
   parameter int T_OFF_MS  = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       overload,
   output logic       k1_main,
   output logic       k2_star,
   output logic       k3_delta,
   output logic       em_falha,
   output logic [2:0] estado
);

   localparam int MS_DIV = ms_div(CLK_HZ);
   localparam int MS_W   = $clog2(max3(T_STAR_MS, T_DEAD_MS, T_OFF_MS)) + 1;
   localparam int PRE_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

   localparam logic [MS_W-1:0] T_STAR_W = MS_W'(T_STAR_MS);
   localparam logic [MS_W-1:0] T_DEAD_W = MS_W'(T_DEAD_MS);
   localparam logic [MS_W-1:0] T_OFF_W  = MS_W'(T_OFF_MS);

   estado_t         state;
   estado_t         prox;
   saidas_t         saida;
   logic            restart;
   logic            done;
   logic [MS_W-1:0] target;

   // Overload beats everything; run=0 beats timer expiry.
   function automatic estado_t proximo_estado(input estado_t s, input logic r,
                                              input logic ovl, input logic d);
      if (ovl && s != FAULT) return FAULT;
      case (s)
         IDLE:    return r ? STAR : IDLE;
         STAR:    return !r ? COOL : (d ? DEAD : STAR);
         DEAD:    return !r ? COOL : (d ? DELTA : DEAD);
         DELTA:   return !r ? COOL : DELTA;
         COOL:    return d ? IDLE : COOL;
         FAULT:   return (!ovl && !r) ? COOL : FAULT;
         default: return FAULT;
      endcase
   endfunction

   // NOTE: next state and its output decode are pure combinational functions
   // of registers and inputs; only the always_ff below holds state, so the
   // outputs are registered copies of the state they belong to.
   assign prox   = proximo_estado(state, run, overload, done);
   assign saida  = decodifica(prox);
   assign target = (state == STAR) ? T_STAR_W :
                   (state == DEAD) ? T_DEAD_W : T_OFF_W;
   assign estado = state;

   temporizador_ms #(
      .MS_DIV (MS_DIV),
      .MS_W   (MS_W),
      .PRE_W  (PRE_W)
   ) u_temporizador (
      .clk       (clk),
      .rst       (rst),
      .restart   (restart),
      .target_ms (target),
      .done      (done)
   );

   // NOTE: non-blocking assignments throughout so every register samples the
   // pre-edge values and the outputs move together with the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         restart  <= 1'b1;
         k1_main  <= 1'b0;
         k2_star  <= 1'b0;
         k3_delta <= 1'b0;
         em_falha <= 1'b0;
      end else begin
         state    <= prox;
         restart  <= (prox != state);
         k1_main  <= saida.k1;
         k2_star  <= saida.k2;
         // Last-stage interlock: delta can never be energised alongside star.
         k3_delta <= saida.k3 & ~saida.k2;
         em_falha <= saida.falha;
      end
   end

endmodule

// File: tb/tb_partida_estrela_triangulo.sv
// ---------------------------------------------------------------------------
// tb_partida_estrela_triangulo
// Scoreboard bench: the driver applies run/overload each cycle, a phase model
// predicts the response and queues it, and a monitor compares after every
// clock edge. CLK_HZ = 1000 so one cycle is one millisecond.
// ---------------------------------------------------------------------------
module tb_partida_estrela_triangulo;

   localparam int T_STAR = 10;
   localparam int T_DEAD = 3;
   localparam int T_OFF  = 5;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       run      = 1'b0;
   logic       overload = 1'b0;
   logic       k1_main;
   logic       k2_star;
   logic       k3_delta;
   logic       em_falha;
   logic [2:0] estado;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] exp_q[$];

   // Phase model: phase code and cycles left in the timed phase.
   int m_phase = 0;
   int m_left  = 0;

   partida_estrela_triangulo #(
      .CLK_HZ    (1000),
      .T_STAR_MS (T_STAR),
      .T_DEAD_MS (T_DEAD),
      .T_OFF_MS  (T_OFF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .overload (overload),
      .k1_main  (k1_main),
      .k2_star  (k2_star),
      .k3_delta (k3_delta),
      .em_falha (em_falha),
      .estado   (estado)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
      end
   endtask

   function automatic int duracao(input int p);
      case (p)
         1:       return T_STAR;
         2:       return T_DEAD;
         4:       return T_OFF;
         default: return 0;
      endcase
   endfunction

   task automatic model_enter(input int p);
      m_phase = p;
      m_left  = duracao(p);
   endtask

   // One clock edge of the starter as the behaviour rules describe it.
   task automatic model_step(input bit r, input bit o);
      if (o && m_phase != 5) begin
         model_enter(5);
      end else begin
         case (m_phase)
            0: if (r) model_enter(1);
            1, 2: begin
               if (!r) model_enter(4);
               else begin
                  m_left--;
                  if (m_left == 0) model_enter(m_phase + 1);
               end
            end
            3: if (!r) model_enter(4);
            4: begin
               m_left--;
               if (m_left == 0) model_enter(0);
            end
            5: if (!o && !r) model_enter(4);
            default: model_enter(5);
         endcase
      end
   endtask

   function automatic logic [6:0] model_out();
      logic k1, k2, k3, f;
      k1 = (m_phase >= 1 && m_phase <= 3);
      k2 = (m_phase == 1);
      k3 = (m_phase == 3);
      f  = (m_phase == 5);
      return {k1, k2, k3, f, 3'(m_phase)};
   endfunction

   task automatic step(input bit r, input bit o, input int n);
      repeat (n) begin
         @(negedge clk);
         run      = r;
         overload = o;
         model_step(r, o);
         exp_q.push_back(model_out());
      end
   endtask

   // Monitor: one queued expectation per clock edge, plus interlock rules.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            check("interlock_k2_k3", {31'd0, k2_star & k3_delta}, 32'd0);
            check("k2k3_need_k1", {31'd0, (k2_star | k3_delta) & ~k1_main}, 32'd0);
            if (exp_q.size() > 0)
               check("outputs_k1k2k3_falha_estado",
                     {25'd0, k1_main, k2_star, k3_delta, em_falha, estado},
                     {25'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      bit r_v;
      bit o_v;
      r_v = 1'b0;
      o_v = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset_outputs", {27'd0, k1_main, k2_star, k3_delta, em_falha, 1'b0},
            32'd0);
      check("reset_estado", {29'd0, estado}, 32'd0);
      rst = 1'b0;
      model_enter(0);

      // Full start: star 10, dead 3, delta.
      step(1, 0, 16);
      // Stop in delta, run pulse inside cool ignored, then restart.
      step(0, 0, 1);
      step(1, 0, 2);
      step(0, 0, 3);
      step(0, 0, 2);
      step(1, 0, 3);
      // Overload in star cycle 4; fault held while run stays high.
      step(1, 0, 1);
      step(1, 1, 1);
      step(1, 0, 3);
      step(0, 0, 1);
      step(0, 0, 6);
      // Star expiry coincident with run release -> cool.
      step(1, 0, 10);
      step(0, 0, 1);
      step(0, 0, 6);
      // Overload and run together in idle -> fault.
      step(1, 1, 1);
      step(0, 0, 1);
      step(0, 0, 6);
      // Asynchronous reset mid-delta.
      step(1, 0, 15);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_contactors", {29'd0, k1_main, k2_star, k3_delta}, 32'd0);
      check("async_reset_estado", {29'd0, estado}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_enter(0);
      step(1, 0, 3);

      // Randomized run/overload.
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(15) == 0) r_v = ~r_v;
         if (!o_v) o_v = ($urandom_range(199) == 0);
         else      o_v = ($urandom_range(7) != 0);
         step(r_v, o_v, 1);
      end

      @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
